// File: rtl/fb_fill_pkg.sv
// Shared definitions for the framebuffer rectangle-fill engine: FSM states,
// register map, CTRL/STAT bit positions and default framebuffer geometry.
package fb_fill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        NEXT_ROW,
        DONE
    } fill_state_t;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_POS   = 2'd1;
    localparam logic [1:0] REG_SIZE  = 2'd2;
    localparam logic [1:0] REG_COLOR = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_DONE_CLR = 2;

    localparam logic [25:0] FB_BASE_DEFAULT   = 26'h0;
    localparam int          FB_WIDTH_DEFAULT  = 800;
    localparam int          FB_HEIGHT_DEFAULT = 480;

endpackage

// File: rtl/fb_rect_fill.sv
// Avalon-MM rectangle-fill engine: a 4-register slave programs a clipped
// RGB565 rectangle that the master port writes into the SDRAM framebuffer.
module fb_rect_fill
    import fb_fill_pkg::*;
#(
    parameter logic [25:0] FB_BASE   = FB_BASE_DEFAULT,
    parameter int          FB_WIDTH  = FB_WIDTH_DEFAULT,
    parameter int          FB_HEIGHT = FB_HEIGHT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  s0_address,
    input  logic        s0_read,
    input  logic        s0_write,
    input  logic        s0_chipselect,
    input  logic [31:0] s0_writedata,
    output logic [31:0] s0_readdata,
    input  logic        m0_waitrequest,
    output logic [25:0] m0_address,
    output logic        m0_write_n,
    output logic        m0_read_n,
    output logic [15:0] m0_writedata,
    output logic        m0_chipselect,
    output logic [1:0]  m0_byteenable_n,
    output logic        irq
);

    fill_state_t state, next_state;

    logic [10:0] pos_x, pos_y, size_w, size_h;
    logic [15:0] color_reg, fill_color;
    logic        irq_en, done_flag;

    logic [10:0] ew, eh, col, row;
    logic [25:0] row_addr;

    logic        reg_wr, start_wr, busy, last_col, last_row, empty;
    logic [11:0] span_x, span_y;
    logic [10:0] clip_w, clip_h;
    logic [25:0] start_addr;
    logic        unused_bits;

    assign reg_wr   = s0_chipselect && s0_write;
    assign start_wr = reg_wr && (s0_address == REG_CTRL) && s0_writedata[CTRL_START];
    assign busy     = (state != IDLE);
    assign last_col = (col == ew - 11'd1);
    assign last_row = (row == eh - 11'd1);

    // Clipping against the visible area; span_* are only meaningful when not empty
    assign span_x     = 12'(FB_WIDTH)  - {1'b0, pos_x};
    assign span_y     = 12'(FB_HEIGHT) - {1'b0, pos_y};
    assign clip_w     = ({1'b0, size_w} < span_x) ? size_w : span_x[10:0];
    assign clip_h     = ({1'b0, size_h} < span_y) ? size_h : span_y[10:0];
    assign empty      = ({1'b0, pos_x} >= 12'(FB_WIDTH)) || ({1'b0, pos_y} >= 12'(FB_HEIGHT)) ||
                        (size_w == 11'd0) || (size_h == 11'd0);
    assign start_addr = FB_BASE + 26'(pos_y) * 26'(FB_WIDTH) + 26'(pos_x);

    assign unused_bits = ^{s0_read, s0_writedata[31:27], s0_writedata[15:11]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x     <= '0;
            pos_y     <= '0;
            size_w    <= '0;
            size_h    <= '0;
            color_reg <= '0;
            irq_en    <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (s0_address)
                    REG_CTRL: begin
                        irq_en <= s0_writedata[CTRL_IRQ_EN];
                        if (s0_writedata[CTRL_DONE_CLR])
                            done_flag <= 1'b0;
                    end
                    REG_POS: begin
                        pos_x <= s0_writedata[10:0];
                        pos_y <= s0_writedata[26:16];
                    end
                    REG_SIZE: begin
                        size_w <= s0_writedata[10:0];
                        size_h <= s0_writedata[26:16];
                    end
                    default: color_reg <= s0_writedata[15:0];
                endcase
            end
            // Completion wins over a coincident DONE_CLR so a finish is never lost
            if (state == DONE)
                done_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        m0_write_n = 1'b1;
        case (state)
            IDLE:     if (start_wr) next_state = SETUP;
            SETUP:    next_state = empty ? DONE : WRITE;
            WRITE: begin
                m0_write_n = 1'b0;
                if (!m0_waitrequest && last_col)
                    next_state = last_row ? DONE : NEXT_ROW;
            end
            NEXT_ROW: next_state = WRITE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Fill datapath: geometry and colour are snapshotted once per fill in SETUP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ew         <= '0;
            eh         <= '0;
            col        <= '0;
            row        <= '0;
            row_addr   <= '0;
            fill_color <= '0;
        end else begin
            case (state)
                SETUP: begin
                    ew         <= clip_w;
                    eh         <= clip_h;
                    col        <= '0;
                    row        <= '0;
                    row_addr   <= start_addr;
                    fill_color <= color_reg;
                end
                WRITE: begin
                    if (!m0_waitrequest && !last_col)
                        col <= col + 11'd1;
                end
                NEXT_ROW: begin
                    row_addr <= row_addr + 26'(FB_WIDTH);
                    col      <= '0;
                    row      <= row + 11'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s0_readdata = '0;
        case (s0_address)
            REG_CTRL:  s0_readdata = {29'b0, done_flag, irq_en, busy};
            REG_POS:   s0_readdata = {5'b0, pos_y, 5'b0, pos_x};
            REG_SIZE:  s0_readdata = {5'b0, size_h, 5'b0, size_w};
            default:   s0_readdata = {16'b0, color_reg};
        endcase
    end

    assign m0_address      = row_addr + 26'(col);
    assign m0_writedata    = fill_color;
    assign m0_chipselect   = !m0_write_n;
    assign m0_read_n       = 1'b1;
    assign m0_byteenable_n = 2'b00;
    assign irq             = done_flag && irq_en;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Scoreboard bench for fb_rect_fill: directed fills push expected pixel writes,
// a negedge monitor pops and compares every accepted master write.
module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s0_address;
    logic        s0_read, s0_write, s0_chipselect;
    logic [31:0] s0_writedata;
    logic [31:0] s0_readdata;
    logic        m0_waitrequest;
    logic [25:0] m0_address;
    logic        m0_write_n, m0_read_n, m0_chipselect;
    logic [15:0] m0_writedata;
    logic [1:0]  m0_byteenable_n;
    logic        irq;

    typedef struct {
        logic [25:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int compared = 0;
    int mismatched = 0;
    int accepted_writes = 0;

    logic        hold_valid = 1'b0;
    logic [25:0] hold_addr;
    logic [15:0] hold_data;

    fb_rect_fill dut (
        .clk             (clk),
        .rst             (rst),
        .s0_address      (s0_address),
        .s0_read         (s0_read),
        .s0_write        (s0_write),
        .s0_chipselect   (s0_chipselect),
        .s0_writedata    (s0_writedata),
        .s0_readdata     (s0_readdata),
        .m0_waitrequest  (m0_waitrequest),
        .m0_address      (m0_address),
        .m0_write_n      (m0_write_n),
        .m0_read_n       (m0_read_n),
        .m0_writedata    (m0_writedata),
        .m0_chipselect   (m0_chipselect),
        .m0_byteenable_n (m0_byteenable_n),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: checks strobe/chipselect coupling, stall hold stability and accepted writes
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            checkOutput("m0_chipselect", {31'b0, m0_chipselect}, {31'b0, !m0_write_n});
            if (!m0_write_n) begin
                if (hold_valid) begin
                    checkOutput("hold_address", {6'b0, m0_address}, {6'b0, hold_addr});
                    checkOutput("hold_data", {16'b0, m0_writedata}, {16'b0, hold_data});
                end
                if (m0_waitrequest) begin
                    hold_valid = 1'b1;
                    hold_addr  = m0_address;
                    hold_data  = m0_writedata;
                end else begin
                    hold_valid = 1'b0;
                    accepted_writes++;
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_write: got addr %h data %h, expected none", m0_address, m0_writedata);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        checkOutput("write_addr", {6'b0, m0_address}, {6'b0, e.addr});
                        checkOutput("write_data", {16'b0, m0_writedata}, {16'b0, e.data});
                    end
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        s0_chipselect = 1'b1;
        s0_write      = 1'b1;
        s0_address    = addr;
        s0_writedata  = data;
        @(negedge clk);
        s0_chipselect = 1'b0;
        s0_write      = 1'b0;
        s0_address    = 2'd0;
        s0_writedata  = '0;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        s0_chipselect = 1'b1;
        s0_read       = 1'b1;
        s0_address    = addr;
        #1;
        data          = s0_readdata;
        s0_chipselect = 1'b0;
        s0_read       = 1'b0;
        s0_address    = 2'd0;
    endtask

    task automatic pushRect(input int base, input int w, input int h, input logic [15:0] color);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                exp_q.push_back('{addr: 26'(base + r * 800 + c), data: color});
    endtask

    // Counts cycles with BUSY=1 starting from the current (post-START) cycle
    task automatic measureBusy(output int cycles);
        bit finished = 0;
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (s0_readdata[0]) cycles++;
            else if (cycles > 0) begin
                finished = 1;
                break;
            end
            @(negedge clk);
        end
        if (!finished) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL busy_timeout: got busy %0d cycles without finishing, expected completion", cycles);
        end
    endtask

    task automatic waitStrobe();
        for (int i = 0; i < 50; i++) begin
            if (!m0_write_n) return;
            @(negedge clk);
        end
        compared++;
        mismatched++;
        $display("[TB] FAIL strobe_timeout: got no write strobe, expected one");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int busy_cycles;
        int writes_before;

        rst            = 1'b1;
        s0_address     = 2'd0;
        s0_read        = 1'b0;
        s0_write       = 1'b0;
        s0_chipselect  = 1'b0;
        s0_writedata   = '0;
        m0_waitrequest = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_write_n", {31'b0, m0_write_n}, 32'd1);
        checkOutput("rst_chipselect", {31'b0, m0_chipselect}, 32'd0);
        checkOutput("rst_address", {6'b0, m0_address}, 32'd0);
        checkOutput("rst_writedata", {16'b0, m0_writedata}, 32'd0);
        checkOutput("read_n_const", {31'b0, m0_read_n}, 32'd1);
        checkOutput("byteenable_const", {30'b0, m0_byteenable_n}, 32'd0);
        checkOutput("rst_irq", {31'b0, irq}, 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            readReg(2'(a), rd);
            checkOutput("rst_reg", rd, 32'd0);
        end

        $display("[TB] basic fill 3x2 at (2,1)");
        applyStimulus(2'd1, 32'h0001_0002);
        applyStimulus(2'd2, 32'h0002_0003);
        applyStimulus(2'd3, 32'h0000_F800);
        readReg(2'd1, rd);
        checkOutput("pos_readback", rd, 32'h0001_0002);
        pushRect(802, 3, 2, 16'hF800);
        writes_before = accepted_writes;
        applyStimulus(2'd0, 32'h1);
        measureBusy(busy_cycles);
        checkOutput("basic_busy", busy_cycles, 32'd9);
        checkOutput("basic_writes", accepted_writes - writes_before, 32'd6);
        readReg(2'd0, rd);
        checkOutput("basic_stat", rd, 32'h4);

        $display("[TB] stalled fill");
        pushRect(802, 3, 2, 16'hF800);
        writes_before = accepted_writes;
        applyStimulus(2'd0, 32'h1);
        fork
            measureBusy(busy_cycles);
            begin
                waitStrobe();
                @(posedge clk);
                #1 m0_waitrequest = 1'b1;
                repeat (3) @(posedge clk);
                #1 m0_waitrequest = 1'b0;
            end
        join
        checkOutput("stall_busy", busy_cycles, 32'd12);
        checkOutput("stall_writes", accepted_writes - writes_before, 32'd6);

        $display("[TB] clipped fill at (798,479)");
        applyStimulus(2'd1, 32'h01DF_031E);
        applyStimulus(2'd2, 32'h000A_000A);
        pushRect(479 * 800 + 798, 2, 1, 16'hF800);
        writes_before = accepted_writes;
        applyStimulus(2'd0, 32'h5);
        readReg(2'd0, rd);
        checkOutput("clip_stat_during", rd, 32'h1);
        measureBusy(busy_cycles);
        checkOutput("clip_writes", accepted_writes - writes_before, 32'd2);
        readReg(2'd0, rd);
        checkOutput("clip_stat_after", rd, 32'h4);

        $display("[TB] degenerate fills");
        applyStimulus(2'd1, 32'h0);
        applyStimulus(2'd2, 32'h0005_0000);
        writes_before = accepted_writes;
        applyStimulus(2'd0, 32'h5);
        measureBusy(busy_cycles);
        checkOutput("zero_w_busy", busy_cycles, 32'd2);
        checkOutput("zero_w_writes", accepted_writes - writes_before, 32'd0);
        readReg(2'd0, rd);
        checkOutput("zero_w_stat", rd, 32'h4);
        applyStimulus(2'd1, 32'h0000_0320);
        applyStimulus(2'd2, 32'h0002_0003);
        applyStimulus(2'd0, 32'h5);
        measureBusy(busy_cycles);
        checkOutput("x800_busy", busy_cycles, 32'd2);
        checkOutput("x800_writes", accepted_writes - writes_before, 32'd0);

        $display("[TB] interrupt");
        applyStimulus(2'd1, 32'h0);
        applyStimulus(2'd2, 32'h0001_0001);
        applyStimulus(2'd3, 32'h0000_07E0);
        pushRect(0, 1, 1, 16'h07E0);
        applyStimulus(2'd0, 32'h7);
        checkOutput("irq_low_busy", {31'b0, irq}, 32'd0);
        measureBusy(busy_cycles);
        checkOutput("irq_fill_busy", busy_cycles, 32'd3);
        checkOutput("irq_high", {31'b0, irq}, 32'd1);
        readReg(2'd0, rd);
        checkOutput("irq_stat", rd, 32'h6);
        applyStimulus(2'd0, 32'h6);
        checkOutput("irq_cleared", {31'b0, irq}, 32'd0);
        readReg(2'd0, rd);
        checkOutput("irq_stat_cleared", rd, 32'h2);

        $display("[TB] register writes and START while busy");
        applyStimulus(2'd1, 32'h0000_000A);
        applyStimulus(2'd2, 32'h0002_0004);
        applyStimulus(2'd3, 32'h0000_001F);
        pushRect(10, 4, 2, 16'h001F);
        writes_before = accepted_writes;
        applyStimulus(2'd0, 32'h1);
        applyStimulus(2'd3, 32'h0000_1234);
        applyStimulus(2'd0, 32'h1);
        applyStimulus(2'd1, 32'h0002_0005);
        measureBusy(busy_cycles);
        checkOutput("midfill_writes", accepted_writes - writes_before, 32'd8);
        checkOutput("midfill_queue", exp_q.size(), 32'd0);
        readReg(2'd3, rd);
        checkOutput("color_readback", rd, 32'h0000_1234);
        applyStimulus(2'd2, 32'h0001_0001);
        pushRect(1605, 1, 1, 16'h1234);
        applyStimulus(2'd0, 32'h1);
        measureBusy(busy_cycles);
        checkOutput("next_fill_busy", busy_cycles, 32'd3);

        $display("[TB] reset mid-fill");
        applyStimulus(2'd1, 32'h0001_0002);
        applyStimulus(2'd2, 32'h0002_0003);
        applyStimulus(2'd3, 32'h0000_F800);
        pushRect(802, 3, 2, 16'hF800);
        applyStimulus(2'd0, 32'h3);
        waitStrobe();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_write_n", {31'b0, m0_write_n}, 32'd1);
        checkOutput("rst_mid_chipselect", {31'b0, m0_chipselect}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        writes_before = accepted_writes;
        for (int a = 0; a < 4; a++) begin
            readReg(2'(a), rd);
            checkOutput("rst_mid_reg", rd, 32'd0);
        end
        checkOutput("rst_mid_address", {6'b0, m0_address}, 32'd0);
        checkOutput("rst_mid_writedata", {16'b0, m0_writedata}, 32'd0);
        checkOutput("rst_mid_irq", {31'b0, irq}, 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("rst_mid_no_resume", accepted_writes - writes_before, 32'd0);

        checkOutput("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fb_rect_fill.md
# fb_rect_fill

Avalon-MM rectangle-fill engine that writes a solid RGB565 colour into the SDRAM framebuffer, one 16-bit pixel per word address. It sits upstream of the LCD display path. The CPU programs position, size and colour through a 4-register slave; the block's master port then drives the SDRAM controller (through the system interconnect) until the clipped rectangle is filled. The display path later reads those pixels out to the panel.

## Interface
- FB_BASE, 26'h0, word address of pixel (0,0)
- FB_WIDTH, 800, framebuffer line pitch and visible width in pixels
- FB_HEIGHT, 480, visible height in pixels
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s0_address  in  2  register select
- s0_read / s0_write / s0_chipselect  in  1  slave strobes; zero wait states
- s0_writedata  in  32  register write data
- s0_readdata  out  32  combinational register read data
- m0_waitrequest  in  1  SDRAM controller stall
- m0_address  out  26  pixel word address
- m0_write_n  out  1  active-low write strobe
- m0_read_n  out  1  constant 1
- m0_writedata  out  16  fill colour
- m0_chipselect  out  1  equals !m0_write_n
- m0_byteenable_n  out  2  constant 2'b00
- irq  out  1  done interrupt, level

## Operation
- Reg 0, CTRL/STAT:
  - Write: bit0 START (write 1 starts; ignored while busy), bit1 IRQ_EN (stored), bit2 DONE_CLR (write 1 clears DONE).
  - Read: {29'b0, DONE, IRQ_EN, BUSY}.
- Reg 1, POS: x=[10:0], y=[26:16].
- Reg 2, SIZE: w=[10:0], h=[26:16].
- Reg 3, COLOR: [15:0].
- Register rules:
  - Unused read bits are 0.
  - Regs 1-3 are writable at any time; the engine copies them in SETUP, so writes during a fill affect only the next fill.
- irq = DONE & IRQ_EN.
- If START and DONE_CLR are written together, DONE clears and the fill starts.
- FSM states:
  - IDLE: on START go to SETUP.
  - SETUP (1 cycle): compute clipping, then:
    - ew = min(w, FB_WIDTH-x) and eh = min(h, FB_HEIGHT-y).
    - If x≥FB_WIDTH, y≥FB_HEIGHT, w=0 or h=0: go to DONE with no writes.
    - Otherwise: row_addr = FB_BASE + y*FB_WIDTH + x (26-bit, wraps mod 2^26), col=0, row=0; go to WRITE.
  - WRITE: assert m0_write_n=0 with m0_address=row_addr+col.
    - Hold address and data stable while m0_waitrequest=1.
    - On acceptance (waitrequest=0): if col=ew-1 and row=eh-1, go to DONE.
    - Else if col=ew-1: go to NEXT_ROW.
    - Else: col++.
  - NEXT_ROW (1 cycle, m0_write_n=1): row_addr += FB_WIDTH, col=0, row++; go to WRITE.
  - DONE (1 cycle): set DONE flag; go to IDLE.
- BUSY = (state != IDLE).
- m0_writedata is the latched colour, stable throughout the fill.

## Timing
- Reset values:
  - state IDLE, m0_write_n=1, m0_chipselect=0, m0_address=0, m0_writedata=0.
  - All registers 0; DONE=0, IRQ_EN=0, irq=0.
- Start sequence: START written at edge N → BUSY reads 1 from N+1 (SETUP) → first write strobe in cycle N+2.
- Busy duration with no stalls: 1 + ew*eh + (eh-1) + 1 cycles. Each waitrequest cycle adds one.
- DONE becomes visible, and BUSY falls, the cycle after the DONE state.
- A clipped-to-empty fill produces exactly 2 busy cycles and zero strobes.
- rst mid-fill: m0_write_n goes high asynchronously and the fill is abandoned; no partial-state resume.

## Structure
- Package fb_fill_pkg holds:
  - state enum (IDLE, SETUP, WRITE, NEXT_ROW, DONE);
  - register offset constants and CTRL bit positions;
  - default geometry constants.
- Single module. The SETUP multiply is a constant-coefficient multiply by FB_WIDTH, done once per fill; no sub-module needed.

## Test plan
- Basic fill: POS x=2,y=1; SIZE 3×2; COLOR 16'hF800; START, no waitrequest → 6 writes at FB_BASE+802..804 and 1602..1604, data F800, one idle-strobe gap between rows; BUSY for 9 cycles; DONE=1.
- Stall: same fill, waitrequest high for 3 cycles on the 2nd pixel → address and data held; exactly 6 accepted writes; BUSY for 12 cycles.
- Clipping: x=798, y=479, 10×10 → writes only at FB_BASE+479*800+798 and +799.
- Degenerate input: w=0, or x=800 → zero strobes, BUSY exactly 2 cycles, DONE set.
- Interrupt and busy handling:
  - IRQ_EN=1 → irq rises with DONE.
  - DONE_CLR drops irq.
  - START while busy is ignored.
  - COLOR written mid-fill leaves the current fill unchanged.
- Reset mid-fill: rst asserted during WRITE → m0_write_n=1 immediately; all registers read 0 after release.
